// File: rtl/axi_common_types_pkg.sv
// Shared AXI payload types and widths for the interconnect.
// Packs the AW/W channel fields and holds the arbiter state encoding.
package axi_common_types_pkg;

   localparam int AXI_ID_WIDTH     = 4;
   localparam int AXI_ADDR_WIDTH   = 32;
   localparam int AXI_LEN_WIDTH    = 8;
   localparam int AXI_SIZE_WIDTH   = 3;
   localparam int AXI_BURST_WIDTH  = 2;
   localparam int AXI_LOCK_WIDTH   = 1;
   localparam int AXI_CACHE_WIDTH  = 4;
   localparam int AXI_PROT_WIDTH   = 3;
   localparam int AXI_QOS_WIDTH    = 4;
   localparam int AXI_REGION_WIDTH = 4;
   localparam int AXI_AWUSER_WIDTH = 1;
   localparam int AXI_DATA_WIDTH   = 32;
   localparam int AXI_STRB_WIDTH   = AXI_DATA_WIDTH / 8;
   localparam int AXI_WUSER_WIDTH  = 1;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]     id;
      logic [AXI_ADDR_WIDTH-1:0]   addr;
      logic [AXI_LEN_WIDTH-1:0]    len;
      logic [AXI_SIZE_WIDTH-1:0]   size;
      logic [AXI_BURST_WIDTH-1:0]  burst;
      logic [AXI_LOCK_WIDTH-1:0]   lock;
      logic [AXI_CACHE_WIDTH-1:0]  cache;
      logic [AXI_PROT_WIDTH-1:0]   prot;
      logic [AXI_QOS_WIDTH-1:0]    qos;
      logic [AXI_REGION_WIDTH-1:0] region;
      logic [AXI_AWUSER_WIDTH-1:0] user;
   } aw_pkt_t;

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0]  data;
      logic [AXI_STRB_WIDTH-1:0]  strb;
      logic [AXI_WUSER_WIDTH-1:0] user;
   } w_pkt_t;

   // Bit position of the len field inside a flattened aw_pkt_t
   localparam int AW_LEN_LSB = AXI_SIZE_WIDTH + AXI_BURST_WIDTH
                             + AXI_LOCK_WIDTH + AXI_CACHE_WIDTH
                             + AXI_PROT_WIDTH + AXI_QOS_WIDTH
                             + AXI_REGION_WIDTH + AXI_AWUSER_WIDTH;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/s5_bid_fifo.sv
// In-order tracking FIFO of master indices awaiting their S5 write response.
// Full/empty are registered from the next-cycle occupancy.
module s5_bid_fifo
   import axi_common_types_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 2
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int PW = idx_w(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count, count_nxt;
   logic          do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      unique case ({do_push, do_pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == (PW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage carries no reset; entries are only read while non-empty
   always_ff @(posedge ACLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/s5_wr_arbiter.sv
// Round-robin AW/W arbiter for the S5 slave port with in-order B routing.
// W stays locked to the granted master until its WLAST beat completes.
module s5_wr_arbiter
   import axi_common_types_pkg::*;
#(
   parameter int NUM_MASTERS     = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int AW_W            = $bits(aw_pkt_t),
   parameter int W_W             = $bits(w_pkt_t)
) (
   input  logic                        ACLK,
   input  logic                        ARESETn,
   input  logic [NUM_MASTERS-1:0]      m_awvalid,
   input  logic [NUM_MASTERS*AW_W-1:0] m_awpkt,
   output logic [NUM_MASTERS-1:0]      m_awready,
   input  logic [NUM_MASTERS-1:0]      m_wvalid,
   input  logic [NUM_MASTERS*W_W-1:0]  m_wpkt,
   input  logic [NUM_MASTERS-1:0]      m_wlast,
   output logic [NUM_MASTERS-1:0]      m_wready,
   output logic [NUM_MASTERS-1:0]      m_bvalid,
   input  logic [NUM_MASTERS-1:0]      m_bready,
   output logic                        S5_AWVALID,
   input  logic                        S5_AWREADY,
   output logic [AW_W-1:0]             s5_awpkt,
   output logic                        S5_WVALID,
   input  logic                        S5_WREADY,
   output logic [W_W-1:0]              s5_wpkt,
   output logic                        S5_WLAST,
   input  logic                        S5_BVALID,
   output logic                        S5_BREADY,
   output logic                        wlast_err
);

   localparam int IDX_W = idx_w(NUM_MASTERS);
   localparam int CNT_W = AXI_LEN_WIDTH + 1;

   arb_state_e               state_q, state_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]         grant_q, grant_d;
   logic [IDX_W-1:0]         pick, rr_idx, rr_next;
   logic                     pick_vld;
   logic [AXI_LEN_WIDTH-1:0] awlen_q, awlen_d;
   logic [CNT_W-1:0]         beat_q, beat_d, beat_inc, len_p1;
   logic                     err_q, err_d;
   logic                     w_hs;
   logic                     fifo_push, fifo_pop;
   logic                     fifo_full, fifo_empty;
   logic [IDX_W-1:0]         bid_head;

   // Descending scan so the requester closest to rr_ptr wins
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      rr_idx   = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         rr_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
         if (m_awvalid[rr_idx]) begin
            pick     = rr_idx;
            pick_vld = 1'b1;
         end
      end
   end

   assign rr_next  = (grant_q == IDX_W'(NUM_MASTERS - 1)) ?
                     '0 : grant_q + 1'b1;
   assign beat_inc = beat_q + CNT_W'(1);
   assign len_p1   = {1'b0, awlen_q} + CNT_W'(1);
   assign w_hs     = m_wvalid[grant_q] && S5_WREADY;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      awlen_d    = awlen_q;
      beat_d     = beat_q;
      err_d      = 1'b0;
      fifo_push  = 1'b0;
      S5_AWVALID = 1'b0;
      s5_awpkt   = '0;
      m_awready  = '0;
      S5_WVALID  = 1'b0;
      s5_wpkt    = '0;
      S5_WLAST   = 1'b0;
      m_wready   = '0;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_vld && !fifo_full) begin
               grant_d = pick;
               awlen_d = m_awpkt[int'(pick)*AW_W + AW_LEN_LSB +: AXI_LEN_WIDTH];
               state_d = ARB_ADDR;
            end
         end
         ARB_ADDR: begin
            S5_AWVALID         = 1'b1;
            s5_awpkt           = m_awpkt[int'(grant_q)*AW_W +: AW_W];
            m_awready[grant_q] = S5_AWREADY;
            if (S5_AWREADY) begin
               fifo_push = 1'b1;
               beat_d    = '0;
               state_d   = ARB_DATA;
            end
         end
         ARB_DATA: begin
            S5_WVALID         = m_wvalid[grant_q];
            s5_wpkt           = m_wpkt[int'(grant_q)*W_W +: W_W];
            S5_WLAST          = m_wlast[grant_q];
            m_wready[grant_q] = S5_WREADY;
            if (w_hs) begin
               beat_d = beat_inc;
               if (m_wlast[grant_q]) begin
                  err_d    = (beat_inc != len_p1);
                  rr_ptr_d = rr_next;
                  state_d  = ARB_IDLE;
               end else begin
                  err_d = (beat_inc == len_p1);
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         awlen_q  <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         awlen_q  <= awlen_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
      end
   end

   assign wlast_err = err_q;

   // B goes to whichever master owns the oldest outstanding AW
   assign S5_BREADY = !fifo_empty && m_bready[bid_head];
   assign m_bvalid  = fifo_empty ? '0 :
                      (NUM_MASTERS'(S5_BVALID) << bid_head);
   assign fifo_pop  = S5_BVALID && S5_BREADY;

   s5_bid_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .DW    (IDX_W)
   ) u_bid_fifo (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .push    (fifo_push),
      .din     (grant_q),
      .pop     (fifo_pop),
      .dout    (bid_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_s5_wr_arbiter.sv
// Directed bench for s5_wr_arbiter: grant order, W locking, B routing,
// outstanding limit, beat-count errors and asynchronous reset.
module tb_s5_wr_arbiter;
   import axi_common_types_pkg::*;

   localparam int NM   = 4;
   localparam int AW_W = $bits(aw_pkt_t);
   localparam int W_W  = $bits(w_pkt_t);

   logic                ACLK    = 1'b0;
   logic                ARESETn = 1'b1;
   logic [NM-1:0]       m_awvalid, m_awready;
   logic [NM*AW_W-1:0]  m_awpkt;
   logic [NM-1:0]       m_wvalid, m_wlast, m_wready;
   logic [NM*W_W-1:0]   m_wpkt;
   logic [NM-1:0]       m_bvalid, m_bready;
   logic                S5_AWVALID, S5_AWREADY;
   logic [AW_W-1:0]     s5_awpkt;
   logic                S5_WVALID, S5_WREADY, S5_WLAST;
   logic [W_W-1:0]      s5_wpkt;
   logic                S5_BVALID, S5_BREADY;
   logic                wlast_err;

   int checks   = 0;
   int failures = 0;
   int hs;
   int order [6] = '{3, 0, 1, 2, 3, 0};

   always #5 ACLK = ~ACLK;

   s5_wr_arbiter #(
      .NUM_MASTERS     (NM),
      .MAX_OUTSTANDING (4)
   ) dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .m_awvalid  (m_awvalid),
      .m_awpkt    (m_awpkt),
      .m_awready  (m_awready),
      .m_wvalid   (m_wvalid),
      .m_wpkt     (m_wpkt),
      .m_wlast    (m_wlast),
      .m_wready   (m_wready),
      .m_bvalid   (m_bvalid),
      .m_bready   (m_bready),
      .S5_AWVALID (S5_AWVALID),
      .S5_AWREADY (S5_AWREADY),
      .s5_awpkt   (s5_awpkt),
      .S5_WVALID  (S5_WVALID),
      .S5_WREADY  (S5_WREADY),
      .s5_wpkt    (s5_wpkt),
      .S5_WLAST   (S5_WLAST),
      .S5_BVALID  (S5_BVALID),
      .S5_BREADY  (S5_BREADY),
      .wlast_err  (wlast_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_aw(input int m, input int len);
      aw_pkt_t p;
      p      = '0;
      p.id   = AXI_ID_WIDTH'(m);
      p.addr = AXI_ADDR_WIDTH'(32'h1000 * (m + 1));
      p.len  = AXI_LEN_WIDTH'(len);
      m_awpkt[m*AW_W +: AW_W] = p;
   endtask

   task automatic set_w(input int m, input logic [31:0] d);
      w_pkt_t p;
      p      = '0;
      p.data = d;
      p.strb = '1;
      m_wpkt[m*W_W +: W_W] = p;
   endtask

   function automatic logic [63:0] aw_id(input logic [AW_W-1:0] v);
      aw_pkt_t p;
      p = v;
      return 64'(p.id);
   endfunction

   function automatic logic [63:0] aw_addr(input logic [AW_W-1:0] v);
      aw_pkt_t p;
      p = v;
      return 64'(p.addr);
   endfunction

   function automatic logic [63:0] w_data(input logic [W_W-1:0] v);
      w_pkt_t p;
      p = v;
      return 64'(p.data);
   endfunction

   initial begin
      m_awvalid  = '0;
      m_awpkt    = '0;
      m_wvalid   = '0;
      m_wpkt     = '0;
      m_wlast    = '0;
      m_bready   = '0;
      S5_AWREADY = 1'b0;
      S5_WREADY  = 1'b0;
      S5_BVALID  = 1'b0;
      for (int m = 0; m < NM; m++) begin
         set_aw(m, 0);
         set_w(m, 32'hD000 + m);
      end
      #1 ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      chk("rst_awvalid", 64'(S5_AWVALID), 64'h0);
      chk("rst_outs", 64'({m_awready, m_wready, m_bvalid,
                           S5_WVALID, S5_BREADY, wlast_err}), 64'h0);
      ARESETn = 1'b1;

      // Single master M2, AWLEN=3
      set_aw(2, 3);
      m_awvalid = 4'b0100;
      settle();
      chk("t1_idle_awvalid", 64'(S5_AWVALID), 64'h0);
      tick();
      chk("t1_awvalid_n1", 64'(S5_AWVALID), 64'h1);
      chk("t1_awaddr", aw_addr(s5_awpkt), 64'h3000);
      chk("t1_awready_lo", 64'(m_awready), 64'h0);
      S5_AWREADY = 1'b1;
      settle();
      chk("t1_awready", 64'(m_awready), 64'h4);
      tick();
      m_awvalid  = '0;
      S5_AWREADY = 1'b0;
      m_wvalid   = 4'b0101;
      S5_WREADY  = 1'b1;
      for (int b = 0; b < 4; b++) begin
         set_w(2, 32'hA0 + b);
         m_wlast = (b == 3) ? 4'b0100 : 4'b0000;
         settle();
         chk("t1_wready", 64'(m_wready), 64'h4);
         chk("t1_wdata", w_data(s5_wpkt), 64'(32'hA0 + b));
         chk("t1_wlast", 64'(S5_WLAST), 64'(b == 3));
         tick();
      end
      settle();
      chk("t1_w_stall_idle", 64'({S5_WVALID, m_wready}), 64'h0);
      chk("t1_no_err", 64'(wlast_err), 64'h0);
      S5_BVALID = 1'b1;
      m_bready  = 4'b0100;
      m_wvalid  = '0;
      m_wlast   = '0;
      settle();
      chk("t1_bvalid", 64'(m_bvalid), 64'h4);
      chk("t1_bready", 64'(S5_BREADY), 64'h1);
      tick();
      settle();
      chk("t1_empty_bvalid", 64'(m_bvalid), 64'h0);
      chk("t1_empty_bready", 64'(S5_BREADY), 64'h0);

      // Fairness: M0/M3 first (rr_ptr=3), then all four requesting
      set_w(2, 32'hD002);
      m_wvalid   = 4'b1111;
      m_wlast    = 4'b1111;
      S5_AWREADY = 1'b1;
      m_bready   = 4'b1111;
      m_awvalid  = 4'b1001;
      settle();
      for (int i = 0; i < 6; i++) begin
         chk("fair_gap", 64'({S5_AWVALID, S5_WVALID, m_wready}), 64'h0);
         tick();
         settle();
         chk("fair_grant_id", aw_id(s5_awpkt), 64'(order[i]));
         chk("fair_awready", 64'(m_awready), 64'h1 << order[i]);
         if (i == 0) m_awvalid = 4'b1111;
         tick();
         settle();
         chk("fair_wready", 64'(m_wready), 64'h1 << order[i]);
         chk("fair_bvalid", 64'(m_bvalid), 64'h1 << order[i]);
         if (i == 5) m_awvalid = '0;
         tick();
         settle();
      end

      // Outstanding limit with B held off
      S5_BVALID = 1'b0;
      m_awvalid = 4'b0010;
      hs = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (S5_AWVALID && S5_AWREADY) hs++;
      end
      chk("bp_aw_count", 64'(hs), 64'h4);
      chk("bp_stalled", 64'(S5_AWVALID), 64'h0);
      chk("bp_no_bvalid", 64'(m_bvalid), 64'h0);
      S5_BVALID = 1'b1;
      m_bready  = 4'b0010;
      settle();
      chk("bp_bvalid", 64'(m_bvalid), 64'h2);
      chk("bp_bready", 64'(S5_BREADY), 64'h1);
      tick();
      S5_BVALID = 1'b0;
      settle();
      chk("bp_still_idle", 64'(S5_AWVALID), 64'h0);
      tick();
      settle();
      chk("bp_fifth_aw", 64'(S5_AWVALID), 64'h1);
      chk("bp_fifth_awready", 64'(m_awready), 64'h2);
      m_awvalid = '0;
      tick();
      tick();
      S5_BVALID = 1'b1;
      m_bready  = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("bp_drain", 64'(m_bvalid), 64'h2);
         tick();
      end
      settle();
      chk("bp_drained", 64'(m_bvalid), 64'h0);
      S5_BVALID = 1'b0;

      // Push (M0 AW) and pop (M3 B) in the same cycle
      m_awvalid = 4'b1000;
      tick();
      settle();
      chk("pp_m3_awready", 64'(m_awready), 64'h8);
      tick();
      m_awvalid = 4'b0001;
      tick();
      tick();
      S5_BVALID = 1'b1;
      settle();
      chk("pp_b_to_m3", 64'(m_bvalid), 64'h8);
      chk("pp_m0_awready", 64'(m_awready), 64'h1);
      tick();
      m_awvalid = '0;
      settle();
      chk("pp_b_to_m0", 64'(m_bvalid), 64'h1);
      tick();
      settle();
      chk("pp_empty_bvalid", 64'(m_bvalid), 64'h0);
      chk("pp_empty_bready", 64'(S5_BREADY), 64'h0);
      S5_BVALID = 1'b0;

      // AWLEN=2 with WLAST on the second beat
      set_aw(2, 2);
      m_wvalid  = 4'b0100;
      m_wlast   = 4'b0000;
      m_awvalid = 4'b0100;
      tick();
      m_awvalid = '0;
      tick();
      settle();
      chk("le_err_lo0", 64'(wlast_err), 64'h0);
      chk("le_wready", 64'(m_wready), 64'h4);
      tick();
      m_wlast = 4'b0100;
      settle();
      chk("le_err_lo1", 64'(wlast_err), 64'h0);
      tick();
      settle();
      chk("le_err_pulse", 64'(wlast_err), 64'h1);
      chk("le_idle", 64'(S5_WVALID), 64'h0);
      tick();
      settle();
      chk("le_err_clear", 64'(wlast_err), 64'h0);

      // AWLEN=0 with WLAST only on the second beat
      set_aw(3, 0);
      m_wvalid  = 4'b1000;
      m_wlast   = 4'b0000;
      m_awvalid = 4'b1000;
      tick();
      m_awvalid = '0;
      tick();
      tick();
      settle();
      chk("ln_err_missing", 64'(wlast_err), 64'h1);
      chk("ln_continues", 64'(S5_WVALID), 64'h1);
      m_wlast = 4'b1000;
      tick();
      settle();
      chk("ln_err_late", 64'(wlast_err), 64'h1);
      tick();
      settle();
      chk("ln_err_clear", 64'(wlast_err), 64'h0);

      // Asynchronous reset at beat 1 of an AWLEN=3 burst
      set_aw(1, 3);
      m_wvalid  = 4'b0010;
      m_wlast   = 4'b0000;
      m_awvalid = 4'b0010;
      tick();
      m_awvalid = '0;
      tick();
      tick();
      S5_BVALID = 1'b1;
      settle();
      chk("ar_in_data", 64'(S5_WVALID), 64'h1);
      chk("ar_b_head_m2", 64'(m_bvalid), 64'h4);
      ARESETn = 1'b0;
      settle();
      chk("ar_outs", 64'({S5_AWVALID, m_awready, S5_WVALID, m_wready,
                          S5_WLAST, m_bvalid, S5_BREADY, wlast_err}),
          64'h0);
      chk("ar_awpkt", 64'(|s5_awpkt), 64'h0);
      chk("ar_wpkt", 64'(|s5_wpkt), 64'h0);
      m_awvalid = 4'b1111;
      m_wvalid  = '0;
      tick();
      ARESETn = 1'b1;
      tick();
      settle();
      chk("ar_grant_m0", aw_id(s5_awpkt), 64'h0);
      chk("ar_awready_m0", 64'(m_awready), 64'h1);
      chk("ar_fifo_empty", 64'({m_bvalid, S5_BREADY}), 64'h0);
      m_awvalid = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/s5_wr_arbiter.md
Name: s5_wr_arbiter

Overview:
- Write-path arbiter for the Slave 5 port of the 4-master/7-slave AXI interconnect.
- Shares the S5 write address (AW) and write data (W) channels among NUM_MASTERS requesters using round-robin arbitration.
- Holds the W channel to the granted master until its WLAST.
- Routes each S5 write response (B) back to its originating master through an in-order tracking FIFO.

Parameters:
- NUM_MASTERS, 4, number of requesting masters.
- MAX_OUTSTANDING, 4, AW handshakes accepted whose B is not yet returned; power of two, 2 to 16.
- AW_W, width of aw_pkt_t (from package), packed AW payload width.
- W_W, width of w_pkt_t (from package), packed W payload width: WDATA, WSTRB, WUSER.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- m_awvalid  in  NUM_MASTERS  per-master AW request.
- m_awpkt  in  NUM_MASTERS*AW_W  per-master AW payload, master i at slice i.
- m_awready  out  NUM_MASTERS  per-master AW ready.
- m_wvalid  in  NUM_MASTERS  per-master W valid.
- m_wpkt  in  NUM_MASTERS*W_W  per-master W payload.
- m_wlast  in  NUM_MASTERS  per-master WLAST.
- m_wready  out  NUM_MASTERS  per-master W ready.
- m_bvalid  out  NUM_MASTERS  routed B valid.
- m_bready  in  NUM_MASTERS  per-master B ready.
- S5_AWVALID/S5_AWREADY  out/in  1/1  slave AW handshake.
- s5_awpkt  out  AW_W  slave AW payload.
- S5_WVALID/S5_WREADY  out/in  1/1  slave W handshake.
- s5_wpkt  out  W_W  slave W payload.
- S5_WLAST  out  1  slave WLAST.
- S5_BVALID/S5_BREADY  in/out  1/1  slave B handshake.
- wlast_err  out  1  one-cycle pulse on a beat-count mismatch.

Behaviour:
- Reset (asynchronous, ARESETn low):
  - State to IDLE; rr_ptr=0; FIFO empty; beat counter 0.
  - All outputs 0.
  - Reset mid-burst abandons the burst and all outstanding B tracking.
- State machine IDLE / ADDR / DATA:
  - IDLE: if any m_awvalid and FIFO not full, latch grant g = first requester at or after rr_ptr (cyclic), latch awlen, go to ADDR. Otherwise stay in IDLE.
  - ADDR: S5_AWVALID=1; s5_awpkt = slice g, passed combinationally; m_awready[g]=S5_AWREADY, all other m_awready bits 0. On the AW handshake, push g into the FIFO, clear the beat counter, go to DATA.
  - DATA: S5_WVALID=m_wvalid[g]; s5_wpkt and S5_WLAST taken from master g; m_wready[g]=S5_WREADY. Each W handshake increments the beat counter. On a handshake with WLAST=1: rr_ptr=(g+1) mod NUM_MASTERS, go to IDLE.
- Latency:
  - A request seen in IDLE at cycle N gives S5_AWVALID at N+1.
  - Minimum of one IDLE cycle between bursts.
- W before AW: a master's W beats are stalled (m_wready=0) until that master is granted and in DATA.
- FIFO full: IDLE issues no grant; requests wait. rr_ptr does not change.
- B routing:
  - m_bvalid[head]=S5_BVALID when the FIFO is non-empty; S5_BREADY=m_bready[head].
  - Pop on the B handshake.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- FIFO empty with S5_BVALID=1: S5_BREADY=0, all m_bvalid 0.
- wlast_err pulses for one cycle, without altering flow, in either case:
  - WLAST handshake with beat count != awlen+1;
  - beat count reaches awlen+1 without WLAST. The burst then continues until WLAST.
- Width rules: beat counter is AXI_LEN_WIDTH+1 bits; rr_ptr and FIFO entries are $clog2(NUM_MASTERS) bits.

Decomposition:
- Shared package axi_common_types_pkg:
  - aw_pkt_t and w_pkt_t packed structs (ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT, QOS, REGION, USER / DATA, STRB, USER);
  - arb_state_e enum;
  - AXI_*_WIDTH constants.
- One sub-module: s5_bid_fifo, a synchronous FIFO with async reset, registered full/empty flags, depth MAX_OUTSTANDING, holding master indices.

Test Plan:
- Single master: M2 issues AWLEN=3 -> S5_AWVALID rises one cycle after the request; 4 W beats from M2 only; B delivered on m_bvalid[2]; rr_ptr=3.
- Fairness: all four masters request continuously, single-beat bursts -> grant order 0,1,2,3,0, each burst separated by one IDLE cycle.
- Backpressure: MAX_OUTSTANDING=4, S5_BVALID held 0, 5 requests -> 4 AW handshakes, 5th stalls in IDLE. One B handshake -> 5th issues.
- Concurrent push/pop: an AW handshake and a B handshake in the same cycle -> FIFO count unchanged; next B routed to the correct master.
- Length error: AWLEN=2 with WLAST on beat 2 -> wlast_err pulses for 1 cycle; state returns to IDLE.
- Async reset asserted mid-DATA at beat 1 -> all outputs 0 immediately; after release, first grant goes to master 0.
